// File: rtl/descriptor_ibi_rx.sv
// IBI receive path: takes the MDB plus payload byte stream from the bus FSM, packs the payload
// little-endian into 32-bit data-queue words and closes each frame with one status descriptor.
module descriptor_ibi_rx #(
    parameter int IbiDataWidth = 32,
    parameter int IbiFifoWidth = 8,
    parameter int MaxDataLen   = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ibi_byte_valid_i,
    output logic                    ibi_byte_ready_o,
    input  logic [IbiFifoWidth-1:0] ibi_byte_i,
    input  logic                    ibi_byte_last_i,
    input  logic                    ibi_byte_err_i,
    output logic                    data_wvalid_o,
    input  logic                    data_wready_i,
    output logic [IbiDataWidth-1:0] data_wdata_o,
    output logic                    desc_wvalid_o,
    input  logic                    desc_wready_i,
    output logic [IbiDataWidth-1:0] desc_wdata_o
);
    typedef enum logic [1:0] {Idle, Collect, PushWord, PushDesc} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [IbiFifoWidth-1:0] mdb_q, mdb_d;
    logic [IbiDataWidth-1:0] word_q, word_d;
    logic                    err_q, err_d, ovf_q, ovf_d, last_q, last_d;
    logic                    rdy, acc, stored;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
            cnt_q   <= '0;
            mdb_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdb_q   <= mdb_d;
            word_q  <= word_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mdb_d         = mdb_q;
        word_d        = word_q;
        err_d         = err_q;
        ovf_d         = ovf_q;
        last_d        = last_q;
        rdy           = 1'b0;
        acc           = 1'b0;
        stored        = 1'b0;
        data_wvalid_o = 1'b0;
        desc_wvalid_o = 1'b0;
        unique case (state_q)
            Idle: begin
                rdy = !rst_i;
                acc = rdy && ibi_byte_valid_i;
                if (acc) begin
                    mdb_d   = ibi_byte_i;
                    cnt_d   = '0;
                    word_d  = '0;
                    err_d   = ibi_byte_err_i;
                    ovf_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = ibi_byte_last_i ? PushDesc : Collect;
                end
            end
            Collect: begin
                rdy = !rst_i;
                acc = rdy && ibi_byte_valid_i;
                if (acc) begin
                    // Past the cap the byte is still consumed so the bus FSM never stalls.
                    if (cnt_q < 8'(MaxDataLen)) begin
                        word_d[{cnt_q[1:0], 3'b000} +: 8] = ibi_byte_i;
                        cnt_d  = cnt_q + 8'd1;
                        stored = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    err_d  = err_q | ibi_byte_err_i;
                    last_d = ibi_byte_last_i;
                    if ((stored && cnt_q[1:0] == 2'd3) || (ibi_byte_last_i && cnt_d[1:0] != 2'd0))
                        state_d = PushWord;
                    else if (ibi_byte_last_i)
                        state_d = PushDesc;
                end
            end
            PushWord: begin
                data_wvalid_o = !rst_i;
                if (data_wready_i) begin
                    word_d  = '0;
                    state_d = last_q ? PushDesc : Collect;
                end
            end
            PushDesc: begin
                desc_wvalid_o = !rst_i;
                if (desc_wready_i) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    assign ibi_byte_ready_o = rdy;
    assign data_wdata_o     = word_q;
    assign desc_wdata_o     = {mdb_q, 8'h00, err_q, ovf_q, 6'b000000, cnt_q};

endmodule

// File: tb/tb_descriptor_ibi_rx.sv
// Directed and randomized frames against a queue-based reference model of the IBI receive path.
module tb_descriptor_ibi_rx;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        ibi_byte_valid_i, ibi_byte_ready_o, ibi_byte_last_i, ibi_byte_err_i;
    logic [7:0]  ibi_byte_i;
    logic        data_wvalid_o, data_wready_i, desc_wvalid_o, desc_wready_i;
    logic [31:0] data_wdata_o, desc_wdata_o;

    descriptor_ibi_rx dut (
        .clk_i(clk), .rst_i(rst_i),
        .ibi_byte_valid_i(ibi_byte_valid_i), .ibi_byte_ready_o(ibi_byte_ready_o),
        .ibi_byte_i(ibi_byte_i), .ibi_byte_last_i(ibi_byte_last_i), .ibi_byte_err_i(ibi_byte_err_i),
        .data_wvalid_o(data_wvalid_o), .data_wready_i(data_wready_i), .data_wdata_o(data_wdata_o),
        .desc_wvalid_o(desc_wvalid_o), .desc_wready_i(desc_wready_i), .desc_wdata_o(desc_wdata_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          sink_mode = 0;   // 0 random, 1 data stalled, 2 always ready
    logic [31:0] dq[$];
    logic [31:0] descq[$];
    logic [7:0]  pay[$];
    bit          perr[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge clk); #1;
    endtask

    // Queue-side sink with its own ready pattern.
    initial begin
        data_wready_i = 1'b0;
        desc_wready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            data_wready_i = (sink_mode == 1) ? 1'b0 : (sink_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            desc_wready_i = (sink_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) if (!rst_i) begin
        if (data_wvalid_o && data_wready_i) dq.push_back(data_wdata_o);
        if (desc_wvalid_o && desc_wready_i) descq.push_back(desc_wdata_o);
    end

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit last, input bit err, input int gapmax);
        int n;
        repeat ($urandom_range(0, gapmax)) align();
        ibi_byte_valid_i = 1'b1;
        ibi_byte_i       = b;
        ibi_byte_last_i  = last;
        ibi_byte_err_i   = err;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ibi_byte_ready_o && n < 2000);
        if (!ibi_byte_ready_o) begin
            checks++; errors++;
            $error("FAIL byte_accept_timeout observed=%0d expected=ready", n);
        end
        align();
        ibi_byte_valid_i = 1'b0;
        ibi_byte_last_i  = 1'b0;
        ibi_byte_err_i   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] mdb, input bit merr);
        send_byte(mdb, pay.size() == 0, merr, 1);
        for (int i = 0; i < pay.size(); i++) send_byte(pay[i], i == pay.size() - 1, perr[i], 1);
    endtask

    // Reference: at most 255 bytes kept, packed 4 per word little-endian, errors OR'd over the frame.
    task automatic check_frame(input string tag, input logic [7:0] mdb, input bit merr);
        logic [31:0] exp_w[$];
        logic [31:0] w, exp_desc;
        int          n, kept, t;
        bit          e;
        n    = pay.size();
        kept = (n > 255) ? 255 : n;
        e    = merr;
        foreach (perr[i]) e |= perr[i];
        w = 0;
        for (int i = 0; i < kept; i++) begin
            w = w | (32'(pay[i]) << (8 * (i % 4)));
            if (i % 4 == 3 || i == kept - 1) begin
                exp_w.push_back(w);
                w = 0;
            end
        end
        exp_desc = {mdb, 8'h00, e, n > 255, 6'b0, 8'(kept)};
        t = 0;
        while (descq.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_desc_cnt"}, descq.size(), 1);
        chk({tag, "_word_cnt"}, dq.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < dq.size(); i++) chk({tag, "_word"}, dq[i], exp_w[i]);
        if (descq.size() > 0) chk({tag, "_desc"}, descq[0], exp_desc);
        dq.delete();
        descq.delete();
        align();
    endtask

    task automatic rand_pay(input int n, input bit with_err);
        pay.delete();
        perr.delete();
        for (int i = 0; i < n; i++) begin
            pay.push_back(8'($urandom));
            perr.push_back(with_err && ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        rst_i = 1'b1;
        ibi_byte_valid_i = 1'b0; ibi_byte_i = '0; ibi_byte_last_i = 1'b0; ibi_byte_err_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ibi_byte_ready_o, 0);
        chk("rst_dvalid", data_wvalid_o, 0);
        chk("rst_descvalid", desc_wvalid_o, 0);
        chk("rst_ddata", data_wdata_o, 0);
        chk("rst_descdata", desc_wdata_o, 0);
        align();
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_ready", ibi_byte_ready_o, 1);
        align();

        // Zero-payload frame.
        pay.delete(); perr.delete();
        send_frame(8'hAE, 0);
        check_frame("t1", 8'hAE, 0);

        // Five bytes: one full word plus a one-lane partial word.
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        perr = '{0, 0, 0, 0, 0};
        send_frame(8'h5A, 0);
        check_frame("t2", 8'h5A, 0);

        // Data queue stalled with a full word pending.
        rand_pay(8, 0);
        sink_mode = 1;
        send_byte(8'h33, 0, 0, 0);
        for (int i = 0; i < 4; i++) send_byte(pay[i], 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", ibi_byte_ready_o, 0);
            chk("t3_stall_dvalid", data_wvalid_o, 1);
        end
        align();
        sink_mode = 0;
        for (int i = 4; i < 8; i++) send_byte(pay[i], i == 7, 0, 0);
        check_frame("t3", 8'h33, 0);

        // Overflow past the byte cap.
        rand_pay(300, 0);
        sink_mode = 2;
        send_frame(8'hC3, 0);
        if (descq.size() == 0) repeat (20) @(negedge clk);
        if (descq.size() > 0) begin
            chk("t4_ovf_bit", descq[0][14], 1);
            chk("t4_len", descq[0][7:0], 8'hFF);
        end
        check_frame("t4", 8'hC3, 0);
        sink_mode = 0;

        // Sticky error on the second payload byte, cleared by the next frame.
        rand_pay(4, 0);
        perr[1] = 1;
        send_frame(8'h42, 0);
        if (descq.size() == 0) repeat (20) @(negedge clk);
        if (descq.size() > 0) chk("t5_err_bit", descq[0][15], 1);
        check_frame("t5", 8'h42, 0);
        rand_pay(3, 0);
        send_frame(8'h43, 0);
        if (descq.size() == 0) repeat (20) @(negedge clk);
        if (descq.size() > 0) chk("t5_next_err_bit", descq[0][15], 0);
        check_frame("t5b", 8'h43, 0);

        // Reset mid-frame: the partial frame leaves nothing behind.
        send_byte(8'h77, 0, 0, 0);
        send_byte(8'h10, 0, 0, 0);
        send_byte(8'h20, 0, 0, 0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_rst_ready", ibi_byte_ready_o, 0);
        chk("t6_rst_ddata", data_wdata_o, 0);
        align();
        rst_i = 1'b0;
        pay = '{8'hAA};
        perr = '{0};
        send_frame(8'h11, 0);
        check_frame("t6", 8'h11, 0);

        // Random frames with random backpressure and occasional errors.
        for (int f = 0; f < 12; f++) begin
            logic [7:0] m;
            bit         me;
            m  = 8'($urandom);
            me = ($urandom_range(0, 7) == 0);
            rand_pay($urandom_range(0, 13), 1);
            sink_mode = (f % 3 == 2) ? 2 : 0;
            send_frame(m, me);
            check_frame("rnd", m, me);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
